// File: rtl/bcd_xs3_codec.sv
// Sequential multi-digit BCD <-> excess-3 converter, one digit per clock, LSD first.
// Optional range checking is enabled by defining BCD_XS3_ERR_CHECK_EN.
module bcd_xs3_codec #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_data,
  input  logic                  mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_data,
  output logic [DIGITS-1:0]     err_mask,
  output logic                  err
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  mode_q, mode_d;
  logic [4*DIGITS-1:0]   src_q, src_d;
  logic [4*DIGITS-1:0]   res_q, res_d;
  logic [4*DIGITS-1:0]   out_q, out_d;
  logic [DIGITS-1:0]     werr_q, werr_d;
  logic [DIGITS-1:0]     emask_q, emask_d;

  logic [3:0]            dig;
  logic [3:0]            conv;
  logic                  bad;

  // Single shared converter working on the digit selected by idx_q.
  always_comb begin
    dig = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) dig = src_q[4*i +: 4];
    end
    conv = mode_q ? (dig + 4'd13) : (dig + 4'd3);
    bad  = 1'b0;
`ifdef BCD_XS3_ERR_CHECK_EN
    bad = mode_q ? ((dig < 4'd3) || (dig > 4'd12)) : (dig > 4'd9);
    if (bad) conv = 4'hF;
`endif
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    src_d   = src_q;
    res_d   = res_q;
    out_d   = out_q;
    werr_d  = werr_q;
    emask_d = emask_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          src_d   = in_data;
          mode_d  = mode;
          idx_d   = '0;
          res_d   = '0;
          werr_d  = '0;
          out_d   = '0;
          emask_d = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        for (int unsigned i = 0; i < DIGITS; i++) begin
          if (idx_q == IW'(i)) begin
            res_d[4*i +: 4] = conv;
            werr_d[i]       = bad;
          end
        end
        idx_d = idx_q + IW'(1);
        // Output registers load only on entry to DONE, so they never show partial words.
        if (idx_q == IW'(DIGITS - 1)) begin
          out_d   = res_d;
          emask_d = werr_d;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mode_q  <= 1'b0;
      src_q   <= '0;
      res_q   <= '0;
      out_q   <= '0;
      werr_q  <= '0;
      emask_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      src_q   <= src_d;
      res_q   <= res_d;
      out_q   <= out_d;
      werr_q  <= werr_d;
      emask_q <= emask_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_q;
  assign err_mask  = emask_q;
  assign err       = |emask_q;

endmodule

// File: doc/bcd_xs3_codec.md
# bcd_xs3_codec

Parametrised, sequential, bidirectional BCD/excess-3 word converter. Accepts a packed multi-digit word over a valid/ready handshake and converts it one digit per clock, LSD first, in the selected direction. Can flag invalid input digits. It replaces single-digit combinational converters wherever multi-digit decimal words move between BCD and XS3 domains, e.g. display and arithmetic front-ends.

## Interface
- `DIGITS`, default 4: number of 4-bit digits per word. Legal values are ≥1.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: input word valid.
- `in_ready`  out  1: block can accept a word. High only in IDLE.
- `in_data`  in  4*DIGITS: packed input digits; digit i is `[4i+3:4i]`.
- `mode`  in  1: 0 = BCD→XS3, 1 = XS3→BCD. Sampled with `in_data`.
- `out_valid`  out  1: converted word available.
- `out_ready`  in  1: downstream accepts the word.
- `out_data`  out  4*DIGITS: converted digits, same packing as `in_data`.
- `err_mask`  out  DIGITS: per-digit invalid-input flags. Bit i corresponds to digit i.
- `err`  out  1: OR of `err_mask`.

## Operation
- FSM states are IDLE, CONV and DONE. Reset enters IDLE.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`, latch `in_data` and `mode`, clear the digit index, the result register and `err_mask`, then go to CONV.
- **CONV:**
  - Each cycle converts latched digit[idx] into result digit[idx], then increments idx.
  - After digit DIGITS-1 is converted, go to DONE.
  - `in_valid` is ignored in CONV.
- **DONE:**
  - `out_valid`=1.
  - `out_data`, `err_mask` and `err` are held stable until `out_valid`&&`out_ready`; then go to IDLE.
- **Arithmetic** (4-bit, modulo 16, carry discarded):
  - mode 0: out = d + 3.
  - mode 1: out = d + 13, i.e. d − 3.
- **Valid input ranges:** 0–9 in mode 0; 3–12 in mode 1.
- **Reset values:**
  - `in_ready`=1
  - `out_valid`=0
  - `out_data`=0
  - `err_mask`=0
  - `err`=0
  - FSM=IDLE
  - idx=0
- **Reset mid-operation** (CONV or DONE): the word in flight is discarded with no output handshake. Reset values apply on the following cycle.
- DIGITS=1 is legal: exactly one CONV cycle.

## Timing
- Input handshake accepted at rising edge T0.
- CONV occupies edges T1..T_DIGITS; `out_valid` rises after edge T_DIGITS.
- Latency from accept to `out_valid` is DIGITS cycles.
- `in_ready` drops after T0. It rises again in the cycle after the output handshake edge.
- Throughput is at most one word per DIGITS+2 cycles with `out_ready` held high.
- No overlap between input and output handshakes: `in_ready` is 0 whenever `out_valid` is 1.
- `out_data`/`err_mask` change only on entry to DONE, on the clear at accept, and on reset. Partial results are not required to be stable during CONV. Consumers must qualify with `out_valid`.

## Configuration
- Macro: `BCD_XS3_ERR_CHECK_EN`.
- **Defined:**
  - A digit outside the valid range for the latched mode sets `err_mask[i]`.
  - That output digit is forced to 4'hF.
  - The other digits convert normally.
- **Undefined:**
  - No range check; every digit uses raw modulo-16 arithmetic.
  - `err_mask` and `err` are tied to 0.
  - Port list is unchanged.

## Test plan
- **BCD→XS3:** DIGITS=4, mode=0, `in_data`=16'h1234, `out_ready`=1 → `out_data`=16'h4567, `err`=0, `out_valid` 4 cycles after accept, high for 1 cycle.
- **XS3→BCD:** mode=1, `in_data`=16'h3C4B → `out_data`=16'h0918, `err`=0. Round-trip of 16'h9870 through mode 0 then mode 1 returns 16'h9870.
- **Invalid digits, macro defined:**
  - mode=0, 16'h9A05 → `out_data`=16'hCF38, `err_mask`=4'b0100, `err`=1.
  - mode=1, 16'h3D32 → `out_data`=16'h0F0F, `err_mask`=4'b0101.
- **Invalid digit, macro undefined:** mode=0, 16'h9A05 → `out_data`=16'hCD38, `err_mask`=0, `err`=0.
- **Backpressure:** `out_ready`=0 for 6 cycles after `out_valid` rises → `out_data`/`err_mask` constant, `in_ready`=0, a new `in_valid` is not accepted. Raising `out_ready` completes the handshake and `in_ready`=1 the next cycle.
- **Reset mid-CONV:** assert `rst` for 1 cycle after 2 CONV cycles → next cycle `out_valid`=0, `out_data`=0, `err`=0, `in_ready`=1. A subsequent word 16'h0000 with mode=0 yields 16'h3333.
